// File: rtl/conv2d_frame_ctrl.sv
// rtl/conv2d_frame_ctrl.sv - frame sequencer between a raster pixel source and the conv2d Sobel datapath
module conv2d_frame_ctrl #(
    parameter int WIDTH_P   = 8,
    parameter int DEPTH_P   = 16,
    parameter int HEIGHT_P  = 16,
    parameter int CLR_CYC_P = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [WIDTH_P-1:0]            data_i,
    output logic                          conv_rstn_o,
    output logic                          conv_valid_o,
    input  logic                          conv_ready_i,
    output logic [WIDTH_P-1:0]            conv_data_o,
    input  logic signed [2*WIDTH_P-1:0]   gx_i,
    input  logic signed [2*WIDTH_P-1:0]   gy_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic signed [2*WIDTH_P-1:0]   gx_o,
    output logic signed [2*WIDTH_P-1:0]   gy_o,
    output logic [$clog2(HEIGHT_P)-1:0]   row_o,
    output logic [$clog2(DEPTH_P)-1:0]    col_o,
    output logic                          eof_o,
    output logic                          frame_done_o
);

    localparam int RW  = $clog2(HEIGHT_P);
    localparam int CW  = $clog2(DEPTH_P);
    localparam int CCW = $clog2(CLR_CYC_P + 1);
    localparam logic [RW-1:0]  LAST_ROW = RW'(HEIGHT_P - 1);
    localparam logic [CW-1:0]  LAST_COL = CW'(DEPTH_P - 1);
    localparam logic [CCW-1:0] CLR_LAST = CCW'(CLR_CYC_P - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [CCW-1:0]               r_clr_cnt;
    logic [RW-1:0]                r_row;
    logic [CW-1:0]                r_col;
    logic                         r_pend;
    logic [RW-1:0]                r_tag_row;
    logic [CW-1:0]                r_tag_col;
    logic                         r_tag_eof;
    logic                         r_out_valid;
    logic signed [2*WIDTH_P-1:0]  r_gx;
    logic signed [2*WIDTH_P-1:0]  r_gy;
    logic [RW-1:0]                r_row_out;
    logic [CW-1:0]                r_col_out;
    logic                         r_eof;

    logic w_run;
    logic w_slot_ok;
    logic w_accept;
    logic w_interior;
    logic w_last_row;
    logic w_last_col;
    logic w_last_px;
    logic w_load;
    logic w_drained;
    logic w_clr_done;

    // A pending window may only be followed by another accept when its result can
    // move into the output register on the same edge; otherwise gx_i would be lost.
    always_comb begin
        w_run        = (r_state == S_RUN);
        w_slot_ok    = !r_pend || !r_out_valid || out_ready_i;
        ready_o      = w_run && conv_ready_i && w_slot_ok;
        conv_valid_o = w_run && valid_i && w_slot_ok;
        w_accept     = valid_i && ready_o;
        w_interior   = (r_row >= RW'(2)) && (r_col >= CW'(2));
        w_last_row   = (r_row == LAST_ROW);
        w_last_col   = (r_col == LAST_COL);
        w_last_px    = w_last_row && w_last_col;
        w_load       = r_pend && (!r_out_valid || out_ready_i);
        w_drained    = !r_pend && !r_out_valid;
        w_clr_done   = (r_clr_cnt == CLR_LAST);
        conv_rstn_o  = (r_state == S_RUN) || (r_state == S_DRAIN);
        conv_data_o  = data_i;
        frame_done_o = (r_state == S_DRAIN) && w_drained;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable_i) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                if (w_clr_done) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_accept && w_last_px) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_drained) w_state_nxt = enable_i ? S_CLEAR : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_clr_cnt   <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_pend      <= 1'b0;
            r_tag_row   <= '0;
            r_tag_col   <= '0;
            r_tag_eof   <= 1'b0;
            r_out_valid <= 1'b0;
            r_gx        <= '0;
            r_gy        <= '0;
            r_row_out   <= '0;
            r_col_out   <= '0;
            r_eof       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= (r_state == S_CLEAR) ? r_clr_cnt + CCW'(1) : '0;

            if (r_state == S_CLEAR) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_accept) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end

            // Tag is the window centre; the gradient for it arrives one cycle later.
            if (w_accept && w_interior) begin
                r_pend    <= 1'b1;
                r_tag_row <= r_row - RW'(1);
                r_tag_col <= r_col - CW'(1);
                r_tag_eof <= w_last_px;
            end else if (w_load) begin
                r_pend <= 1'b0;
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_gx        <= gx_i;
                r_gy        <= gy_i;
                r_row_out   <= r_tag_row;
                r_col_out   <= r_tag_col;
                r_eof       <= r_tag_eof;
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign gx_o        = r_gx;
    assign gy_o        = r_gy;
    assign row_o       = r_row_out;
    assign col_o       = r_col_out;
    assign eof_o       = r_eof;

endmodule
